// File: rtl/bin2csd_encoder.sv
// Iterative two's-complement to canonical-signed-digit encoder, D digits per clock, LSB first.
// Digit code: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1; digit i carries weight +2^i.
module bin2csd_encoder #(
   parameter int unsigned W = 64,
   parameter int unsigned D = 1
) (
   input  logic                       clk,
   input  logic                       srst_n,
   input  logic                       enable,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2*W-1:0]             out_csd,
   output logic [$clog2(W+1)-1:0]     out_nzd
);

   localparam int unsigned STEPS = W / D;
   localparam int unsigned CW    = $clog2(STEPS + 1);
   localparam int unsigned NZW   = $clog2(W + 1);
   localparam int unsigned CSW   = 2 * W;

   if (D == 0 || (W % D) != 0) begin : g_bad_d
      $error("bin2csd_encoder: W must be a nonzero multiple of D");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [W-1:0]    opnd;
   logic            carry;
   logic [CW-1:0]   cnt;

   logic [2*D-1:0]  dig;
   logic [NZW-1:0]  nz_step;
   logic            carry_nx;
   logic            c;
   logic            x;
   logic            xn;

   // One D-digit slice of the carry recurrence; the operand is kept sign-extended by the
   // arithmetic shift, so opnd[j+1] already supplies x_{i+1} including the x_W = x_{W-1} case.
   always_comb begin
      c       = carry;
      x       = 1'b0;
      xn      = 1'b0;
      dig     = '0;
      nz_step = '0;
      for (int j = 0; j < int'(D); j++) begin
         x  = opnd[j];
         xn = (j + 1 < int'(W)) ? opnd[j + 1] : opnd[W - 1];
         // Nonzero digit iff x_i + c_i is odd; its sign is -1 exactly when a carry leaves.
         if (x ^ c) begin
            dig[2*j +: 2] = xn ? 2'b10 : 2'b01;
            nz_step       = nz_step + NZW'(1);
         end
         c = (x & xn) | (x & c) | (xn & c);
      end
      carry_nx = c;
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_csd   <= '0;
         out_nzd   <= '0;
         opnd      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opnd     <= in_data;
                  carry    <= 1'b0;
                  out_csd  <= '0;
                  out_nzd  <= '0;
                  cnt      <= CW'(STEPS);
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (enable) begin
                  opnd    <= W'($signed(opnd) >>> D);
                  carry   <= carry_nx;
                  // New digits enter at the top so digit 0 lands at the bottom after STEPS shifts.
                  out_csd <= CSW'({dig, out_csd} >> (2 * D));
                  out_nzd <= out_nzd + nz_step;
                  cnt     <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bin2csd_encoder.md
Name: bin2csd_encoder

Overview:
- Iterative binary-to-canonical-signed-digit (CSD) encoder.
- Takes a W-bit two's-complement word and produces a W-digit CSD word in the 2-bit-per-digit format that the csd2bin decoder consumes.
- Used to build CSD LUT contents and X_n/Y_n operands in the BKM datapath. It also serves as the stimulus generator for lut_decoder benches, so an encode followed by csd2bin returns the original word.
- Processes D digits per clock, LSB first, behind valid/ready handshakes on both sides.

Parameters:
- W, 64: input word width and number of output CSD digits.
- D, 1: digits produced per clock. W mod D must be 0; elaboration fails otherwise.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- srst_n, input, 1: synchronous reset, active-low.
- enable, input, 1: iteration enable; see Behaviour.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: encoder can accept a word.
- in_data, input, W: two's-complement operand.
- out_valid, output, 1: out_csd and out_nzd are valid.
- out_ready, input, 1: consumer accepts the result.
- out_csd, output, 2*W: CSD result; digit i is held in bits [2i+1:2i].
- out_nzd, output, $clog2(W+1): count of nonzero digits in out_csd.

Behaviour:
- Reset and clocking: one clock domain. Reset is synchronous and active-low; srst_n low at a rising edge forces the reset state.
- Digit encoding:
  - 2'b00 = 0, 2'b01 = +1, 2'b10 = -1.
  - 2'b11 is never generated.
  - Digit i has weight +2^i. The top digit is not negatively weighted.
- Algorithm, for i = 0..W-1, with carry c_0 = 0 and x_W = x_{W-1} (sign extension):
  - c_{i+1} = floor((x_i + x_{i+1} + c_i) / 2)
  - d_i = x_i + c_i - 2*c_{i+1}
  - The final carry is discarded.
  - The resulting sum of d_i * 2^i equals signed(in_data) exactly for every input, including -2^(W-1).
  - No two adjacent digits are both nonzero.
- FSM states:
  - IDLE: in_ready=1.
    - in_valid & in_ready at an edge: latch in_data into the shift register, clear the carry, csd register and nz counter, load the digit counter with W/D, go to BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Each edge with enable=1 produces D digits, shifts the operand right by D, and updates the carry and nz count.
    - When the counter reaches 0, go to DONE.
    - Edges with enable=0 change no state.
  - DONE: out_valid=1; out_csd and out_nzd are held stable.
    - out_valid & out_ready at an edge: go to IDLE.
- Effect of enable: enable gates only BUSY iteration. IDLE acceptance and DONE handoff do not depend on it.
- Latency: out_valid rises exactly W/D enabled edges after the accept edge.
- Throughput: one word per W/D+2 cycles. The encoder does not accept a new input in the same cycle as the output handshake.
- Outputs are registered. out_csd and out_nzd hold their last result in IDLE until the next accept, at which point they clear.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_csd=0, out_nzd=0, carry=0, counter=0.
- Reset mid-operation (BUSY or DONE): the result is abandoned. Next cycle the block is in IDLE with out_valid=0, and no partial result is ever presented.
- Reset has priority over every other event, including a simultaneous handshake.
- Protocol guarantees:
  - out_valid never drops without an out_ready handshake, except by reset.
  - in_valid asserted while not ready is ignored and not queued.
- out_nzd range is 0..W/2 rounded up; the maximum occurs for alternating patterns.

Test Plan:
1. W=8, D=1, in_data=8'h07 -> exactly 8 enabled edges after accept, out_valid=1, out_csd=16'h0042 (+8, -1), out_nzd=2.
2. W=8, in_data=8'h80 and 8'hFF in back-to-back transactions -> 16'h8000 with nzd=1, then 16'h0002 with nzd=1. in_ready stays low from the accept edge until after the out handshake.
3. W=8, D=2, in_data=8'h55 -> out_valid after 4 edges, out_csd=16'h1111, out_nzd=4. With out_ready held low for 5 cycles, the output stays stable and in_ready stays 0.
4. enable deasserted for 3 cycles mid-BUSY -> latency grows by exactly 3 and the result is unchanged.
5. srst_n low during BUSY, and separately in DONE with out_ready=1 -> next cycle IDLE with out_valid=0, out_csd=0, in_ready=1.
6. W=16, D=4, random and exhaustive corner inputs (0, 1, -1, max, min) checked through a csd2bin scoreboard:
   - decoded value equals in_data;
   - no adjacent nonzero digits;
   - no 2'b11 digits;
   - out_nzd matches a reference popcount.
